tlc_sensor_conditioner: RTL and testbench

Front-end stage for the farm-road traffic-light controller. Takes the raw, asynchronous farm-road vehicle-loop sensor and produces the clean car-waiting request the controller samples as its sensor input. The request is latched until the controller grants the farm road. Internally the block synchronises, debounces, edge-detects, and counts arrivals since the last grant.

---
 rtl/tlc_sensor_conditioner.sv | 105 ++++++++++
 tb/tb_tlc_sensor_conditioner.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlc_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tlc_sensor_conditioner
// Brief    : Farm-road loop-sensor front end: sync, debounce, arrival count,
//            latched car-waiting request cleared by grant.
// Revision : 1.0 - initial release
// ============================================================================
module tlc_sensor_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             sensor_raw,
  input  logic             grant,
  output logic             req,
  output logic             sensor_clean,
  output logic [CNT_W-1:0] car_count,
  output logic             overflow
);

  localparam int               DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_s1;
  logic             r_s2;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_clean;
  logic             r_clean_d;
  logic             r_grant_d;
  logic             r_req;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_arrival;
  logic             w_grant_fall;

  // Two-flop synchroniser keeps running while disabled so s2 is fresh on resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= sensor_raw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt <= '0;
      r_clean  <= 1'b0;
    end else if (ena) begin
      if (r_s2 == r_clean) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_clean  <= r_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign w_arrival    = r_clean & ~r_clean_d;
  assign w_grant_fall = r_grant_d & ~grant;

  // Grant wins over everything; a car still on the loop at grant end re-requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clean_d <= 1'b0;
      r_grant_d <= 1'b0;
      r_req     <= 1'b0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
    end else if (ena) begin
      r_clean_d <= r_clean;
      r_grant_d <= grant;
      if (grant) begin
        r_req <= 1'b0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (w_grant_fall && r_clean) begin
        r_req <= 1'b1;
        r_cnt <= CNT_W'(1);
      end else if (w_arrival) begin
        r_req <= 1'b1;
        if (r_cnt == CNT_MAX) begin
          r_ovf <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign req          = r_req;
  assign sensor_clean = r_clean;
  assign car_count    = r_cnt;
  assign overflow     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_tlc_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlc_sensor_conditioner
// Brief    : Directed plus random checks of tlc_sensor_conditioner against a
//            window-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tlc_sensor_conditioner;

  localparam int DB  = 4;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic          sensor_raw = 1'b0;
  logic          grant = 1'b0;
  logic          req;
  logic          sensor_clean;
  logic [CW-1:0] car_count;
  logic          overflow;

  int n_cmp = 0;
  int n_bad = 0;

  tlc_sensor_conditioner #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .sensor_raw  (sensor_raw),
    .grant       (grant),
    .req         (req),
    .sensor_clean(sensor_clean),
    .car_count   (car_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit m_s1, m_s2, m_clean, m_clean_d, m_grant_d, m_req, m_ovf;
  int m_cnt;
  bit m_hist[$];   // s2 as seen at each enabled edge

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_clean = 0; m_clean_d = 0; m_grant_d = 0;
    m_req = 0; m_ovf = 0; m_cnt = 0;
    m_hist.delete();
  endtask

  task automatic model_edge();
    bit arr, gf, differ;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (ena) begin
      arr = m_clean && !m_clean_d;
      gf  = m_grant_d && !grant;
      m_clean_d = m_clean;
      m_grant_d = grant;
      if (grant) begin
        m_req = 0; m_cnt = 0; m_ovf = 0;
      end else if (gf && m_clean_d) begin
        m_req = 1; m_cnt = 1;
      end else if (arr) begin
        m_req = 1;
        if (m_cnt == MAX) m_ovf = 1;
        else m_cnt = m_cnt + 1;
      end
      // level accepted once the last DB enabled samples all disagree with it
      m_hist.push_back(m_s2);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      if (m_hist.size() == DB) begin
        differ = 1;
        foreach (m_hist[i]) if (m_hist[i] == m_clean_d) differ = 0;
        if (differ) m_clean = ~m_clean;
      end
    end
    m_s2 = m_s1;
    m_s1 = sensor_raw;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string t);
    chk({t, ".req"},   32'(req),          32'(m_req));
    chk({t, ".clean"}, 32'(sensor_clean), 32'(m_clean));
    chk({t, ".cnt"},   32'(car_count),    32'(m_cnt));
    chk({t, ".ovf"},   32'(overflow),     32'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic ticks(input int n, input string t);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_model(t);
    end
  endtask

  task automatic pulse_arrival(input string t);
    sensor_raw = 1'b1;
    ticks(7, t);
    sensor_raw = 1'b0;
    ticks(7, t);
  endtask

  // grant with the sensor low so the grant end does not re-request
  task automatic clear_by_grant(input string t);
    sensor_raw = 1'b0;
    grant = 1'b1;
    ticks(7, t);
    grant = 1'b0;
    ticks(1, t);
  endtask

  int run_len;

  initial begin
    model_reset();
    // reset state
    ticks(2, "rst");
    chk("rst_req", 32'(req), 0);
    chk("rst_cnt", 32'(car_count), 0);
    rst_n = 1'b1;

    // glitch of 3 cycles
    sensor_raw = 1'b1;
    ticks(3, "glitch");
    sensor_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_model("glitch");
      chk("glitch_clean", 32'(sensor_clean), 0);
      chk("glitch_req",   32'(req), 0);
    end

    // clean arrival latency
    sensor_raw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("arr_clean_early", 32'(sensor_clean), 0);
    end
    tick();
    chk("arr_clean_e5", 32'(sensor_clean), 1);
    chk("arr_req_e5",   32'(req), 0);
    tick();
    chk("arr_req_e6", 32'(req), 1);
    chk("arr_cnt_e6", 32'(car_count), 1);
    chk_model("arr");
    sensor_raw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("fall_clean_hold", 32'(sensor_clean), 1);
    end
    tick();
    chk("fall_clean", 32'(sensor_clean), 0);
    chk("fall_req_kept", 32'(req), 1);
    chk_model("fall");

    // saturation
    clear_by_grant("sat_clr");
    chk("sat_clr_cnt", 32'(car_count), 0);
    for (int k = 1; k <= 17; k++) begin
      pulse_arrival("sat");
      chk("sat_cnt", 32'(car_count), 32'((k > MAX) ? MAX : k));
      chk("sat_ovf", 32'(overflow), 32'(k > MAX));
    end

    // grant cycle
    clear_by_grant("gc_clr");
    for (int k = 0; k < 5; k++) pulse_arrival("gc_arr");
    chk("gc_cnt5", 32'(car_count), 5);
    chk("gc_req1", 32'(req), 1);
    grant = 1'b1;
    tick();
    chk("gc_req0", 32'(req), 0);
    chk("gc_cnt0", 32'(car_count), 0);
    sensor_raw = 1'b1;
    ticks(8, "gc_during");
    chk("gc_drop_req", 32'(req), 0);
    chk("gc_drop_cnt", 32'(car_count), 0);
    chk("gc_drop_clean", 32'(sensor_clean), 1);
    grant = 1'b0;
    tick();
    chk("gc_fall_req", 32'(req), 1);
    chk("gc_fall_cnt", 32'(car_count), 1);
    chk_model("gc_fall");

    // enable freeze
    clear_by_grant("en_clr");
    chk("en_clr_req", 32'(req), 0);
    ena = 1'b0;
    sensor_raw = 1'b1;
    tick();
    grant = 1'b1;
    tick();
    grant = 1'b0;
    ticks(8, "en_frozen");
    chk("en_frozen_clean", 32'(sensor_clean), 0);
    chk("en_frozen_req", 32'(req), 0);
    ena = 1'b1;
    for (int i = 0; i < DB - 1; i++) begin
      tick();
      chk("en_clean_wait", 32'(sensor_clean), 0);
    end
    tick();
    chk("en_clean_rise", 32'(sensor_clean), 1);
    chk("en_req_wait", 32'(req), 0);
    tick();
    chk("en_req_rise", 32'(req), 1);
    chk_model("en_resume");

    // asynchronous reset mid-run
    clear_by_grant("ar_clr");
    for (int k = 0; k < 3; k++) pulse_arrival("ar_arr");
    chk("ar_pre_cnt", 32'(car_count), 3);
    chk("ar_pre_req", 32'(req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_req", 32'(req), 0);
    chk("ar_cnt", 32'(car_count), 0);
    chk("ar_clean", 32'(sensor_clean), 0);
    chk("ar_ovf", 32'(overflow), 0);
    ticks(2, "ar_low");
    rst_n = 1'b1;

    // randomized traffic
    run_len = 0;
    for (int i = 0; i < 600; i++) begin
      if (run_len == 0) begin
        sensor_raw = ~sensor_raw;
        run_len = $urandom_range(12, 1);
      end
      run_len--;
      if ($urandom_range(19, 0) == 0) grant = ~grant;
      ena = ($urandom_range(14, 0) != 0);
      tick();
      chk_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
